fetch_pc_unit: RTL and testbench

IF-stage program-counter owner and instruction-fetch sequencer for the 5-stage MIPS pipeline. Consumes redirect targets produced downstream: jump targets from ID and branch targets from EX. Issues word fetches to instruction memory over a req/ack handshake and presents {pc, instr} to the IF/ID register through a one-entry output slot plus one skid entry. Handles stall, flush-on-redirect and discard of in-flight fetches.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 49 ++++
 rtl/fetch_pc_unit.sv | 120 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: state encoding, widths and the
// {pc, instr} packet carried from instruction memory to IF/ID.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry output slot backed by one skid entry. The slot drains when it is
// not stalled; the skid refills it first, otherwise the same-cycle load does.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       stall,
  input  logic       load,
  input  fetch_pkt_t load_pkt,
  output logic       valid,
  output fetch_pkt_t slot
);

  fetch_pkt_t skid;
  logic       skid_full;
  logic       slot_free;

  assign slot_free = !valid || !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      slot      <= '0;
      skid      <= '0;
      skid_full <= 1'b0;
    end else if (flush) begin
      valid     <= 1'b0;
      skid_full <= 1'b0;
    end else if (slot_free) begin
      if (skid_full) begin
        slot      <= skid;
        valid     <= 1'b1;
        skid_full <= load;
        if (load) skid <= load_pkt;
      end else if (load) begin
        slot  <= load_pkt;
        valid <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
    end else if (load) begin
      skid      <= load_pkt;
      skid_full <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC owner and fetch sequencer with redirect flush and drain of
// in-flight fetches. Optional FETCH_ALIGN_CHECK_EN traps misaligned targets.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_ALIGN_CHECK_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_valid_i,
  input  logic [31:0] jump_addr_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_addr_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
`ifdef FETCH_ALIGN_CHECK_EN
  , output logic      misalign_o
`endif
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_r;
  logic [31:0]  drain_addr_r;
  logic [31:0]  redirect_raw;
  logic [31:0]  redirect_tgt;
  logic         redirect;
  logic         ack_req;
  logic         load;
  logic         slot_free;
  fetch_pkt_t   fetched;
  fetch_pkt_t   slot;

  // Branch comes from the older instruction, so it wins over a jump.
  assign redirect     = branch_valid_i | jump_valid_i;
  assign redirect_raw = branch_valid_i ? branch_addr_i : jump_addr_i;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned   = redirect_raw[1:0] != 2'b00;
  assign redirect_tgt = misaligned ? EXC_VECTOR : redirect_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) misalign_o <= 1'b0;
    else        misalign_o <= redirect && misaligned;
  end
`else
  assign redirect_tgt = redirect_raw;
`endif

  assign imem_req_o = (state == REQ) || (state == DRAIN);

  always_comb begin
    imem_addr_o = '0;
    case (state)
      REQ:     imem_addr_o = pc_r;
      DRAIN:   imem_addr_o = drain_addr_r;
      default: imem_addr_o = '0;
    endcase
  end

  assign ack_req   = (state == REQ) && imem_ack_i;
  assign load      = ack_req && !redirect;
  assign slot_free = !valid_o || !stall_i;
  assign fetched   = '{pc: pc_r, instr: imem_rdata_i};

  // The skid only fills when the slot cannot take the ack, so that condition
  // alone decides REQ -> FULL; FULL exits when the stalled slot drains.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = (imem_req_o && !imem_ack_i) ? DRAIN : REQ;
    end else begin
      case (state)
        IDLE:    state_nxt = REQ;
        REQ:     if (imem_ack_i && !slot_free) state_nxt = FULL;
        FULL:    if (!stall_i) state_nxt = REQ;
        DRAIN:   if (imem_ack_i) state_nxt = REQ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc_r         <= RESET_PC;
      drain_addr_r <= '0;
    end else begin
      state <= state_nxt;
      if (redirect)     pc_r <= redirect_tgt;
      else if (ack_req) pc_r <= pc_r + PC_INC;
      // A redirect in DRAIN keeps the address of the original request.
      if (redirect && state == REQ) drain_addr_r <= pc_r;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .stall    (stall_i),
    .load     (load),
    .load_pkt (fetched),
    .valid    (valid_o),
    .slot     (slot)
  );

  assign pc_o    = slot.pc;
  assign instr_o = slot.instr;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed sequences, a redirect vector
// table and randomized stall/redirect traffic against a stream-level model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic        branch_valid;
  logic [31:0] branch_addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int lat      = 0;
  int wcnt     = 0;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_valid_i   (jump_valid),
    .jump_addr_i    (jump_addr),
    .branch_valid_i (branch_valid),
    .branch_addr_i  (branch_addr),
    .stall_i        (stall),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .valid_o        (valid),
    .pc_o           (pc),
    .instr_o        (instr)
`ifdef FETCH_ALIGN_CHECK_EN
    , .misalign_o   (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    if (t[1:0] != 2'b00) return 32'h0000_0080;
`endif
    return t;
  endfunction

  // Instruction memory with a programmable wait count per request.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_ack ? memf(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: delivered instructions run consecutively from the last
  // redirect target; fetch addresses follow the same rule except acks that
  // belong to requests abandoned by a redirect.
  logic [31:0] m_exp_pc, m_exp_fetch, m_hold_addr, m_raw;
  bit          m_discard, m_pend, m_prev_mis, m_redir;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_exp_pc    = RST_PC;
      m_exp_fetch = RST_PC;
      m_discard   = 1'b0;
      m_pend      = 1'b0;
      m_prev_mis  = 1'b0;
    end else begin
      m_redir = branch_valid || jump_valid;
      m_raw   = branch_valid ? branch_addr : jump_addr;
`ifdef FETCH_ALIGN_CHECK_EN
      check("misalign_pulse", 32'(misalign), 32'(m_prev_mis));
`endif
      m_prev_mis = m_redir && (m_raw[1:0] != 2'b00);
      if (m_pend) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", imem_addr, m_hold_addr);
      end
      if (valid && !stall && !m_redir) begin
        check("stream_pc", pc, m_exp_pc);
        check("stream_instr", instr, memf(m_exp_pc));
        m_exp_pc = m_exp_pc + 32'd4;
        n_deliv++;
      end
      if (imem_req && imem_ack) begin
        if (!m_discard && !m_redir) begin
          check("fetch_addr", imem_addr, m_exp_fetch);
          m_exp_fetch = m_exp_fetch + 32'd4;
        end
        m_discard = 1'b0;
      end
      if (m_redir) begin
        m_exp_pc    = eff_target(m_raw);
        m_exp_fetch = eff_target(m_raw);
        if (imem_req && !imem_ack) m_discard = 1'b1;
      end
      m_pend      = imem_req && !imem_ack;
      m_hold_addr = imem_addr;
    end
  end

  typedef struct {
    int          lat;
    bit          bv;
    logic [31:0] ba;
    bit          jv;
    logic [31:0] ja;
    logic [31:0] exp;
  } redir_vec_t;

  redir_vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   32'(imem_req), 32'd0);
    check({tag, "_addr"},  imem_addr, 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_pc"},    pc, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check({tag, "_misalign"}, 32'(misalign), 32'd0);
`endif
  endtask

  task automatic apply_redirect(input redir_vec_t v);
    bit found;
    lat   = v.lat;
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_req && (v.lat == 0 || !imem_ack)) found = 1'b1;
    end
    check("vec_pending", 32'(found), 32'd1);
    branch_valid = v.bv; branch_addr = v.ba;
    jump_valid   = v.jv; jump_addr   = v.ja;
    step();
    branch_valid = 1'b0; jump_valid = 1'b0;
    check("vec_flush", 32'(valid), 32'd0);
    if (v.lat == 0) begin
      check("vec_addr_n1", imem_addr, v.exp);
      step();
      check("vec_valid_n2", 32'(valid), 32'd1);
      check("vec_pc_n2", pc, v.exp);
    end else begin
      for (int i = 0; i < 30 && !(imem_req && imem_addr == v.exp); i++) step();
      check("vec_addr", imem_addr, v.exp);
      for (int i = 0; i < 30 && !valid; i++) step();
      check("vec_valid", 32'(valid), 32'd1);
      check("vec_pc", pc, v.exp);
    end
    check("vec_instr", instr, memf(v.exp));
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    logic [31:0] p;
    logic [31:0] exp_odd;
    int          deliv_before;
    bit          found;

`ifdef FETCH_ALIGN_CHECK_EN
    exp_odd = 32'h0000_0080;
`else
    exp_odd = 32'h0000_1002;
`endif
    vecs[0] = '{lat: 3, bv: 0, ba: 32'h0,         jv: 1, ja: 32'h0040_0100, exp: 32'h0040_0100};
    vecs[1] = '{lat: 0, bv: 1, ba: 32'h0000_0200, jv: 1, ja: 32'h0000_0300, exp: 32'h0000_0200};
    vecs[2] = '{lat: 1, bv: 1, ba: 32'h0000_0ABC, jv: 0, ja: 32'h0,         exp: 32'h0000_0ABC};
    vecs[3] = '{lat: 0, bv: 0, ba: 32'h0,         jv: 1, ja: 32'h0000_1002, exp: exp_odd};
    vecs[4] = '{lat: 2, bv: 1, ba: 32'h1000_0000, jv: 1, ja: 32'h2000_0000, exp: 32'h1000_0000};

    rst_n = 1'b0; stall = 1'b0;
    jump_valid = 1'b0; jump_addr = '0;
    branch_valid = 1'b0; branch_addr = '0;
    lat = 0;
    repeat (3) step();
    check_reset_state("reset");
    rst_n = 1'b1;

    // Zero-wait, no stall: one fetch and one delivery per cycle.
    for (int k = 1; k <= 6; k++) begin
      step();
      check("seq_req", 32'(imem_req), 32'd1);
      check("seq_addr", imem_addr, 32'(4 * (k - 1)));
      if (k >= 2) begin
        check("seq_valid", 32'(valid), 32'd1);
        check("seq_pc", pc, 32'(4 * (k - 2)));
      end
    end

    // Stall three cycles: skid fills, request drops, output held.
    p = pc;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_valid", 32'(valid), 32'd1);
      check("stall_pc", pc, p);
    end
    check("stall_req_low", 32'(imem_req), 32'd0);
    stall = 1'b0;
    step();
    check("release_pc1", pc, p + 32'd4);
    step();
    check("release_pc2", pc, p + 32'd8);

    foreach (vecs[i]) apply_redirect(vecs[i]);

    // PC wrap at the top of the address space.
    lat = 0; stall = 1'b0;
    jump_valid = 1'b1; jump_addr = 32'hFFFF_FFF8;
    step();
    jump_valid = 1'b0;
    check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    step();
    check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_a2", imem_addr, 32'h0000_0000);
    check("wrap_req", 32'(imem_req), 32'd1);

    // Reset while a slow fetch is outstanding.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_req && !imem_ack) found = 1'b1;
    end
    check("midreset_pending", 32'(found), 32'd1);
    rst_n = 1'b0;
    step();
    check_reset_state("midreset");
    rst_n = 1'b1;
    for (int i = 0; i < 30 && !valid; i++) step();
    check("midreset_valid", 32'(valid), 32'd1);
    check("midreset_pc", pc, RST_PC);

    // Random stall/redirect traffic at each memory latency.
    for (int l = 0; l <= 3; l++) begin
      lat = l;
      for (int c = 0; c < 250; c++) begin
        step();
        stall        = ($urandom_range(0, 9) < 3);
        branch_valid = ($urandom_range(0, 99) < 4);
        jump_valid   = ($urandom_range(0, 99) < 4);
        branch_addr  = rand_target();
        jump_addr    = rand_target();
      end
      step();
      stall = 1'b0; branch_valid = 1'b0; jump_valid = 1'b0;
      deliv_before = n_deliv;
      repeat (30) step();
      check("liveness", 32'(n_deliv > deliv_before), 32'd1);
    end

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
